// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, falling-edge start detection,
// mid-bit sampling, and a single-entry valid/ready holding register.
module uart_rx #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int C  = CLK_HZ / BAUD_RATE;
    localparam int H  = C / 2;
    localparam int TW = (C <= 2) ? 1 : $clog2(C);

    localparam logic [TW-1:0] HALF_LAST = TW'(H - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(C - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          rxd_prev_q, rxd_prev_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rxd_s;

    assign rxd_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[0], rxd};
        rxd_prev_d  = rxd_s;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                // Only a real high-to-low transition starts a frame, so a held break
                // cannot retrigger after its framing error.
                if (!rxd_s && rxd_prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            rxd_prev_q  <= 1'b1;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rxd_prev_q  <= rxd_prev_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_valid  = valid_q;
    assign rx_data   = data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at C=10, H=5: frames are bit-banged on rxd, delivered bytes are
// checked against a scoreboard queue, flag pulses are counted by a negedge monitor.
module tb_uart_rx;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int C         = 10;
    localparam int H         = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int hs_cnt = 0;
    int fall_cyc;
    int rise_cyc;
    int busy_cnt;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: flag pulses, valid rise time, and scoreboard pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && !valid_prev) rise_cyc = cyc;
            if (rx_valid && rx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
        valid_prev = rx_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        wait_cyc(C);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic clear_counts();
        fe_cnt = 0;
        ov_cnt = 0;
        hs_cnt = 0;
    endtask

    initial begin
        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        wait_cyc(3);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        rst = 1'b0;
        wait_cyc(5);

        // Single byte, held until consumed; latency = 2 sync + 96 cycles.
        clear_counts();
        rise_cyc = -1000;
        exp_q.push_back(8'hA5);
        fall_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        check("t1_latency", 32'(rise_cyc - fall_cyc), 32'd98);
        wait_cyc(20);
        check("t1_valid_held", {31'd0, rx_valid}, 32'd1);
        check("t1_data_held", {24'd0, rx_data}, 32'hA5);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("t1_valid_fall", {31'd0, rx_valid}, 32'd0);
        check("t1_hs", 32'(hs_cnt), 32'd1);
        check("t1_flags", 32'(fe_cnt + ov_cnt), 32'd0);

        // Back-to-back frames with the consumer always ready.
        clear_counts();
        rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cyc(5);
        check("t2_hs", 32'(hs_cnt), 32'd2);
        check("t2_overrun", 32'(ov_cnt), 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t2_valid_idle", {31'd0, rx_valid}, 32'd0);
        rx_ready = 1'b0;

        // Overrun: second byte dropped, first byte retained.
        clear_counts();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_cyc(5);
        check("t3_overrun", 32'(ov_cnt), 32'd1);
        check("t3_data_kept", {24'd0, rx_data}, 32'h3C);
        check("t3_valid", {31'd0, rx_valid}, 32'd1);
        check("t3_ferr", 32'(fe_cnt), 32'd0);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Framing error followed by a long break, then a clean frame.
        clear_counts();
        send_frame(8'h55, 1'b0);
        rxd = 1'b0;
        wait_cyc(30 * C);
        check("t4_ferr_once", 32'(fe_cnt), 32'd1);
        check("t4_valid", {31'd0, rx_valid}, 32'd0);
        check("t4_busy_break", {31'd0, rx_busy}, 32'd0);
        rxd = 1'b1;
        wait_cyc(2 * C);
        send_frame(8'h12, 1'b1);
        wait_cyc(5);
        check("t4_valid_12", {31'd0, rx_valid}, 32'd1);
        check("t4_data_12", {24'd0, rx_data}, 32'h12);
        check("t4_flags", 32'(fe_cnt + ov_cnt), 32'd1);

        // Short glitch shorter than H: busy for H cycles, no outputs.
        clear_counts();
        busy_cnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            if (rx_busy) busy_cnt++;
        end
        rxd = 1'b1;
        for (int i = 0; i < 27; i++) begin
            wait_cyc(1);
            if (rx_busy) busy_cnt++;
        end
        check("t5_busy_cycles", 32'(busy_cnt), 32'(H));
        check("t5_flags", 32'(fe_cnt + ov_cnt + hs_cnt), 32'd0);
        check("t5_data_kept", {24'd0, rx_data}, 32'h12);

        // Reset in the middle of data bit 4.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(i % 2));
        rxd = 1'b1;
        wait_cyc(5);
        check("t6_busy_pre", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("t6_rst_data", {24'd0, rx_data}, 32'd0);
        check("t6_rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        exp_q.delete();
        wait_cyc(3);
        rst = 1'b0;
        clear_counts();
        wait_cyc(5);
        rx_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_cyc(5);
        check("t6_hs", 32'(hs_cnt), 32'd1);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t6_flags", 32'(fe_cnt + ov_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: samples the `rxd` line at the system clock and deserializes 8N1 frames (1 start, 8 data LSB-first, 1 stop) at `baud_rate`. It presents each good byte on a valid/ready output with single-entry holding, and flags framing errors and overruns. It is the receive-side counterpart of the UART transmitter and sits between the board RX pin and the byte consumer.

## Interface
- `clk_hz`, 50_000_000: system clock frequency in Hz.
- `baud_rate`, 115_200: line bit rate.
- Derived `clks_per_bit` C = clk_hz/baud_rate (integer division). Derived half-bit H = C/2 (floor). Requirement: C >= 4.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `rxd`  input  1  serial line, idle high; asynchronous to `clk`.
- `rx_ready`  input  1  consumer accepts `rx_data` when high with `rx_valid`.
- `rx_valid`  output  1  a byte is held on `rx_data`.
- `rx_data`  output  8  received byte; stable while `rx_valid`=1.
- `frame_err`  output  1  1-cycle pulse: stop bit sampled low.
- `overrun`  output  1  1-cycle pulse: a good frame completed while the holding register was full and not being consumed.
- `rx_busy`  output  1  high whenever state != IDLE.

## Operation
- Synchronizer: two flops on `rxd`, both reset to 1. Output `rxd_s` lags `rxd` by 2 cycles. A registered `rxd_prev` (reset 1) holds the previous `rxd_s`.
- Timer: counts clocks within a bit. Width is 1 bit if C<=2, else ceil(log2 C). Cleared on every state entry and after every sample.
- Bit counter: 3 bits. Shift register: 8 bits, filled LSB first (shift right, new bit into bit 7).
- IDLE:
  - Go to START on a falling edge, i.e. `rxd_s`=0 and `rxd_prev`=1.
  - A line held low without an edge does not start a frame, so a break produces at most one framing error.
- START:
  - Sample after H cycles.
  - `rxd_s`=0 -> DATA. `rxd_s`=1 -> IDLE as a glitch; no flags raised.
- DATA:
  - Sample every C cycles into the shift register.
  - After the 8th sample -> STOP.
- STOP: sample after C cycles, then go to IDLE.
  - Sample 1, holding register empty or `rx_ready`=1 this cycle: load `rx_data`, set `rx_valid`.
  - Sample 1, holding register full and `rx_ready`=0: pulse `overrun`, drop the new byte, keep the old byte.
  - Sample 0: pulse `frame_err`, discard the byte, leave `rx_valid`/`rx_data` unchanged.
- Output handshake:
  - `rx_valid` && `rx_ready` in a cycle consumes the byte; `rx_valid` falls next cycle unless a new byte loads in the same cycle.
  - Consume and load in the same cycle: `rx_valid` stays 1, `rx_data` takes the new byte, no overrun.
  - `rx_ready` while `rx_valid`=0 has no effect.
- Reset, asynchronous and valid at any point including mid-frame:
  - State = IDLE; timer and bit counter = 0; synchronizer and `rxd_prev` = 1.
  - `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - A partial frame is lost.
  - If `rxd` is low at reset release, an edge is seen 2 cycles later and a frame attempt starts.

## Timing
- Let cycle E be the first cycle with `rxd_s`=0 after `rxd_s`=1, i.e. 2 cycles after the pin falls.
- State = START from E+1.
- Start sample at cycle E+H.
- Data bit i (0..7) sampled at cycle E+H+(i+1)·C.
- Stop sample at cycle E+H+9·C.
- `rx_valid` high, `frame_err` pulse or `overrun` pulse appear in cycle E+H+9·C+1.
- `rx_busy` is high from E+1 through E+H+9·C.
- The earliest next edge detection is in cycle E+H+9·C+1 (IDLE), which supports back-to-back frames with zero idle gap.
- Sampling point is mid-bit ±1 cycle, plus 2 cycles of synchronizer lag, for tolerance to transmitter baud mismatch up to about ±4% at C>=16.
- Flag pulses are exactly 1 cycle. `rx_valid` is level-held until consumed.

## Test plan
Bench parameters: clk_hz=1_000_000, baud_rate=100_000, giving C=10, H=5.

- Reset, then send byte 8'hA5 with `rx_ready`=0 -> `rx_valid`=1 and `rx_data`=8'hA5 exactly E+96 cycles after edge detection. No flags. `rx_valid` holds until `rx_ready` is pulsed, then falls the next cycle.
- Send 8'h00 then 8'hFF back-to-back (no idle gap) with `rx_ready` tied 1 -> two one-cycle-spaced-by-frame `rx_valid` pulses carrying 8'h00 then 8'hFF. `overrun`=0.
- Send 8'h3C with `rx_ready`=0, then 8'hC3 with `rx_ready`=0 -> `overrun` pulses once at the end of the second frame. `rx_data` stays 8'h3C.
- Send 8'h55 with the stop bit driven low, then hold the line low for 30 bit times -> exactly one `frame_err` pulse and `rx_valid` stays 0. After the line returns high, 8'h12 is received correctly.
- Pulse `rxd` low for 3 cycles (shorter than H) -> state returns to IDLE. No `rx_valid`, `frame_err` or `overrun`; `rx_busy` is high for H cycles only.
- Assert `rst` during data bit 4 of a frame -> all outputs go to reset values immediately. The next full frame, 8'h81, is received correctly.
